fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//  F-stage program counter.
//  - Consumes the D-stage redirect controls PC_sel, b_j_jr_sel and ERET_PC_sel, plus the CP0 exception request.
//  - Computes branch, jump and jr targets; holds PC_F.
//  - Drives the IM fetch address, F_valid, the F/D flush and the fetch address-error flag (AdEL) toward CP0.
//  - Uses MIPS delayed-branch semantics: a redirect from D replaces the PC after the delay slot currently in F.
// PARAMETERS
//  RESET_PC     32'h0000_3000  PC loaded on reset
//  HANDLER_PC   32'h0000_4180  exception entry address
//  IM_BASE      32'h0000_3000  lowest legal fetch address
//  IM_WORDS     4096           IM depth in words; legal range [IM_BASE, IM_BASE+4*IM_WORDS)
//  BOOT_CYCLES  2              fetch-invalid cycles after reset release (1..15)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  stall        in   1   hazard-unit hold of F/D
//  PC_sel       in   1   D-stage redirect taken (branch/j/jal/jr/jalr)
//  b_j_jr_sel   in   2   0: branch, 1: j/jal, 2: jr/jalr, 3: reserved (treated as 0)
//  ERET_PC_sel  in   1   eret in D
//  D_PC4        in   32  PC+4 of the instruction in D
//  D_imm16      in   16  branch offset field
//  D_index      in   26  j/jal instr_index
//  D_RS         in   32  forwarded rs value (jr target)
//  EPC          in   32  CP0 EPC
//  exc_req      in   1   CP0 exception/interrupt entry (committed at M)
//  PC_F         out  32  current fetch address
//  PC4_F        out  32  PC_F + 4
//  F_valid      out  1   fetch is real (0 during BOOT)
//  F_flush      out  1   kill the instruction in F (combinational)
//  F_AdEL       out  1   PC_F misaligned or outside IM range
// BEHAVIOUR
//  Reset (async): PC_F=RESET_PC, state=BOOT, boot_cnt=0, F_valid=0.
//   - F_flush and F_AdEL then follow from inputs and PC_F.
//  Targets (32-bit, wrap mod 2^32):
//   - br = D_PC4 + {{14{imm[15]}}, imm, 2'b00}
//   - jt = {D_PC4[31:28], D_index, 2'b00}
//   - jr = D_RS
//  FSM:
//   - BOOT: PC_F held; boot_cnt increments.
//     - Go to RUN when boot_cnt == BOOT_CYCLES-1; F_valid=1 from the next cycle.
//     - All redirect inputs are ignored in BOOT.
//   - RUN: next PC by strict priority:
//     1. exc_req -> HANDLER_PC. Overrides stall.
//     2. stall -> hold PC_F. Redirects are not latched; D re-presents them.
//     3. ERET_PC_sel -> EPC. No delay slot.
//     4. PC_sel -> br / jt / jr per b_j_jr_sel.
//     5. Otherwise PC_F + 4.
//  F_flush = RUN & ~stall & ERET_PC_sel & ~exc_req.
//   - Squashes the wrong-path word after eret.
//   - For exc_req, the flush comes from CP0, not this block.
//  F_AdEL = F_valid & (PC_F[1:0]!=0 | PC_F<IM_BASE | PC_F>=IM_BASE+4*IM_WORDS).
//   - The PC still advances sequentially from a bad PC until CP0 raises exc_req.
//  Latency: a redirect decided in cycle n appears on PC_F in cycle n+1.
//  Reset asserted mid-run or mid-BOOT: immediate return to reset values; no clock edge needed.
// TESTING
//  T1 reset release -> PC_F=0x3000, F_valid=0 for 2 cycles, then PC_F 0x3000, 0x3004, 0x3008.
//  T2 PC_sel=1, b_j_jr_sel=0, D_PC4=0x3008, imm=0xFFFF -> next PC_F=0x3004.
//  T3 jal: D_PC4=0x3010, index=0x0000C05 -> PC_F=0x3014; jr D_RS=0x3002 -> PC_F=0x3002, F_AdEL=1.
//  T4 stall=1 with PC_sel=1 -> PC_F holds 2 cycles; exc_req during stall -> PC_F=0x4180 next cycle.
//  T5 ERET_PC_sel=1, EPC=0x3040 -> F_flush=1 same cycle, PC_F=0x3040 next; with exc_req=1 also -> 0x4180, F_flush=0.
//  T6 sequential fetch to 0x6FFC then 0x7000 -> F_AdEL 0 then 1; async reset mid-cycle -> PC_F=0x3000 immediately.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - F-stage program counter with delayed-branch redirect
//
// Holds PC_F and picks the next fetch address from the D-stage redirect
// controls, eret and the CP0 exception request. Holds fetch invalid for
// BOOT_CYCLES cycles after reset is released.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   stall              hazard-unit hold of F/D
//   PC_sel             D-stage redirect taken
//   b_j_jr_sel         0 branch, 1 j/jal, 2 jr/jalr, 3 treated as branch
//   ERET_PC_sel        eret in D
//   D_PC4, D_imm16,
//   D_index, D_RS      target operands from D
//   EPC                CP0 exception return address
//   exc_req            CP0 exception/interrupt entry
//   PC_F, PC4_F        current fetch address and its successor
//   F_valid            fetch is real (low while booting)
//   F_flush            kill the word in F (combinational)
//   F_AdEL             PC_F misaligned or outside instruction memory
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
  parameter logic [31:0] IM_BASE     = 32'h0000_3000,
  parameter int          IM_WORDS    = 4096,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PC_sel,
  input  logic [1:0]  b_j_jr_sel,
  input  logic        ERET_PC_sel,
  input  logic [31:0] D_PC4,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_index,
  input  logic [31:0] D_RS,
  input  logic [31:0] EPC,
  input  logic        exc_req,
  output logic [31:0] PC_F,
  output logic [31:0] PC4_F,
  output logic        F_valid,
  output logic        F_flush,
  output logic        F_AdEL
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] IM_END   = IM_BASE + (32'(IM_WORDS) << 2);
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] br_target, jt_target;

  // Targets are computed unconditionally; the mux below picks one.
  assign br_target = D_PC4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
  assign jt_target = {D_PC4[31:28], D_index, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 4'd0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    F_flush    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Redirect inputs are meaningless until the pipe has filled.
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // exc_req wins even over stall: the exception entry must not wait.
        if (exc_req) begin
          pc_d = HANDLER_PC;
        end else if (stall) begin
          // Redirects are dropped here; D keeps presenting them.
          pc_d = pc_q;
        end else if (ERET_PC_sel) begin
          // eret has no delay slot, so the word already fetched is squashed.
          pc_d    = EPC;
          F_flush = 1'b1;
        end else if (PC_sel) begin
          case (b_j_jr_sel)
            2'd1:    pc_d = jt_target;
            2'd2:    pc_d = D_RS;
            default: pc_d = br_target;
          endcase
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign PC_F    = pc_q;
  assign PC4_F   = pc_q + 32'd4;
  assign F_valid = (state_q == ST_RUN);

  // A bad PC keeps advancing sequentially; CP0 turns this flag into exc_req.
  assign F_AdEL = F_valid & ((pc_q[1:0] != 2'b00) | (pc_q < IM_BASE) | (pc_q >= IM_END));

endmodule
